// File: rtl/sync_fifo_pkg.sv
// Shared types and sizing helpers for the sync_fifo_sf credit buffer.
// No logic: compile-time constants and helper functions only.
// No flow control: purely declarative.
package sync_fifo_pkg;

    // Error reporting flavour: sticky until reset, or a one-cycle pulse per fault.
    typedef enum logic {
        ERR_STICKY    = 1'b0,
        ERR_PER_CYCLE = 1'b1
    } err_mode_e;

    // Reset scope: wipe the storage array as well, or only pointers/count/error.
    typedef enum logic {
        RST_CLR_MEM  = 1'b0,
        RST_PTR_ONLY = 1'b1
    } rst_mode_e;

    // Status flags, all derived from the registered occupancy count.
    typedef struct packed {
        logic empty;
        logic almost_empty;
        logic half_full;
        logic almost_full;
        logic full;
    } fifo_flags_t;

    // Pointer width addressing 0..depth-1 (at least one bit).
    function automatic int ptr_width(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

    // Count width holding 0..depth inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/sync_fifo_sf_ctl.sv
// Pointer/count/flag/error controller for sync_fifo_sf.
// Latency: flags and error update one clock after the accepting edge.
// Backpressure: push refused while full, pop refused while empty; refusals flag error.
// Optional SYNC_FIFO_DIAG_EN: diag_n low synchronously clears error.
module sync_fifo_sf_ctl
    import sync_fifo_pkg::*;
#(
    parameter int depth    = 5,
    parameter int ae_level = 1,
    parameter int af_level = 1,
    parameter int err_mode = 0,
    parameter int pw       = ptr_width(depth)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_req_n,
    input  logic          pop_req_n,
    input  logic          diag_n,
    output logic          wr_en,
    output logic [pw-1:0] wr_ptr,
    output logic [pw-1:0] rd_ptr,
    output fifo_flags_t   flags,
    output logic          error
);

    localparam int cw = cnt_width(depth);

    localparam logic [pw-1:0] PTR_LAST = pw'(depth - 1);
    localparam logic [cw-1:0] CNT_FULL = cw'(depth);
    localparam logic [cw-1:0] AE_THR   = cw'(ae_level);
    localparam logic [cw-1:0] HF_THR   = cw'((depth + 1) / 2);
    localparam logic [cw-1:0] AF_THR   = cw'(depth - af_level);

    logic [cw-1:0] count;
    logic [cw-1:0] count_nxt;
    logic [pw-1:0] wr_ptr_nxt;
    logic [pw-1:0] rd_ptr_nxt;
    logic          error_nxt;

    logic is_empty;
    logic is_full;
    logic push_ok;
    logic pop_ok;
    logic fault;

    // Depth need not be a power of two, so pointers wrap explicitly.
    function automatic logic [pw-1:0] bump(input logic [pw-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    assign is_empty = (count == '0);
    assign is_full  = (count == CNT_FULL);

    // Acceptance uses the registered state, so a pop while full still frees
    // a slot only on the following cycle; likewise push while empty.
    assign push_ok = !push_req_n && !is_full;
    assign pop_ok  = !pop_req_n && !is_empty;
    assign fault   = (!push_req_n && is_full) || (!pop_req_n && is_empty);

    // Reset wins over a same-cycle push, so storage is never written then.
    assign wr_en = push_ok && !rst;

    // Next pointers and count from the accepted operations.
    always_comb begin
        wr_ptr_nxt = wr_ptr;
        rd_ptr_nxt = rd_ptr;
        count_nxt  = count;
        if (push_ok) begin
            wr_ptr_nxt = bump(wr_ptr);
        end
        if (pop_ok) begin
            rd_ptr_nxt = bump(rd_ptr);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase
    end

    // Next error state: sticky accumulate or per-cycle fault, optional clear.
    always_comb begin
        error_nxt = error;
        if (err_mode == int'(ERR_PER_CYCLE)) begin
            error_nxt = fault;
        end else begin
            error_nxt = error | fault;
        end
`ifdef SYNC_FIFO_DIAG_EN
        if (!diag_n) begin
            error_nxt = 1'b0;
        end
`endif
    end

`ifndef SYNC_FIFO_DIAG_EN
    // Port kept for interface compatibility; intentionally ignored here.
    logic unused_diag_n;
    assign unused_diag_n = diag_n;
`endif

    // Register pointers, count and error; synchronous reset dominates.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            error  <= 1'b0;
        end else begin
            wr_ptr <= wr_ptr_nxt;
            rd_ptr <= rd_ptr_nxt;
            count  <= count_nxt;
            error  <= error_nxt;
        end
    end

    // Status flags decoded from the registered count.
    always_comb begin
        flags              = '0;
        flags.empty        = is_empty;
        flags.almost_empty = (count <= AE_THR);
        flags.half_full    = (count >= HF_THR);
        flags.almost_full  = (count >= AF_THR);
        flags.full         = is_full;
    end

endmodule

// File: rtl/sync_fifo_sf.sv
// Single-clock FIFO with static flags and active-low push/pop (NoC credit buffer).
// Latency: first-word fall-through; a pushed word is visible on data_out the cycle after the edge.
// Backpressure: push ignored when full, pop ignored when empty; either raises error.
// Optional SYNC_FIFO_DIAG_EN: diag_n low synchronously clears error.
module sync_fifo_sf
    import sync_fifo_pkg::*;
#(
    parameter int width    = 16,
    parameter int depth    = 5,
    parameter int ae_level = 1,
    parameter int af_level = 1,
    parameter int err_mode = 0,
    parameter int rst_mode = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_req_n,
    input  logic             pop_req_n,
    input  logic             diag_n,
    input  logic [width-1:0] data_in,
    output logic             empty,
    output logic             almost_empty,
    output logic             half_full,
    output logic             almost_full,
    output logic             full,
    output logic             error,
    output logic [width-1:0] data_out
);

    localparam int pw = ptr_width(depth);

    logic [width-1:0] mem [depth];
    logic             wr_en;
    logic [pw-1:0]    wr_ptr;
    logic [pw-1:0]    rd_ptr;
    fifo_flags_t      flags;

    sync_fifo_sf_ctl #(
        .depth    (depth),
        .ae_level (ae_level),
        .af_level (af_level),
        .err_mode (err_mode),
        .pw       (pw)
    ) u_ctl (
        .clk        (clk),
        .rst        (rst),
        .push_req_n (push_req_n),
        .pop_req_n  (pop_req_n),
        .diag_n     (diag_n),
        .wr_en      (wr_en),
        .wr_ptr     (wr_ptr),
        .rd_ptr     (rd_ptr),
        .flags      (flags),
        .error      (error)
    );

    // Storage write; optionally wiped on reset so data_out reads zero afterwards.
    always_ff @(posedge clk) begin
        if (rst && (rst_mode == int'(RST_CLR_MEM))) begin
            for (int i = 0; i < depth; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_ptr] <= data_in;
        end
    end

    // Head of queue straight from storage; stale content when empty.
    assign data_out = mem[rd_ptr];

    assign empty        = flags.empty;
    assign almost_empty = flags.almost_empty;
    assign half_full    = flags.half_full;
    assign almost_full  = flags.almost_full;
    assign full         = flags.full;

endmodule

// File: tb/tb_sync_fifo_sf.sv
// Self-checking bench for sync_fifo_sf (width 16, depth 5, ae 1, af 1, sticky error).
// Stimulus updates a queue-based reference and posts expectations; a monitor checks them.
// Inputs change #1 after the rising edge; outputs are sampled on the falling edge.
module tb_sync_fifo_sf;

    localparam int W  = 16;
    localparam int D  = 5;
    localparam int AE = 1;
    localparam int AF = 1;

    logic         clk = 1'b0;
    logic         rst;
    logic         push_req_n;
    logic         pop_req_n;
    logic         diag_n;
    logic [W-1:0] data_in;
    logic         empty;
    logic         almost_empty;
    logic         half_full;
    logic         almost_full;
    logic         full;
    logic         error;
    logic [W-1:0] data_out;

    always #5 clk = ~clk;

    sync_fifo_sf #(
        .width    (W),
        .depth    (D),
        .ae_level (AE),
        .af_level (AF),
        .err_mode (0),
        .rst_mode (1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .push_req_n   (push_req_n),
        .pop_req_n    (pop_req_n),
        .diag_n       (diag_n),
        .data_in      (data_in),
        .empty        (empty),
        .almost_empty (almost_empty),
        .half_full    (half_full),
        .almost_full  (almost_full),
        .full         (full),
        .error        (error),
        .data_out     (data_out)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: FIFO contents as a plain queue plus the sticky error bit.
    logic [W-1:0] mdl_q[$];
    bit           mdl_err;

    // Scoreboard queues filled by stimulus, drained by the monitor.
    logic [W-1:0] data_q[$];
    logic [5:0]   stat_q[$];

    // Expected {empty, almost_empty, half_full, almost_full, full, error}.
    function automatic logic [5:0] exp_stat(input int c, input bit e);
        return {c == 0, c <= AE, c >= (D + 1) / 2, c >= D - AF, c == D, e};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus: post expectations for the current state, then advance the model.
    task automatic drive(input bit do_push, input bit do_pop, input logic [W-1:0] d,
                         input bit do_rst, input bit do_diag);
        int  n;
        bit  push_ok;
        bit  pop_ok;
        bit  fault;
        push_req_n = !do_push;
        pop_req_n  = !do_pop;
        data_in    = d;
        rst        = do_rst;
        diag_n     = !do_diag;
        n = mdl_q.size();
        stat_q.push_back(exp_stat(n, mdl_err));
        if (do_rst) begin
            mdl_q.delete();
            mdl_err = 1'b0;
        end else begin
            push_ok = do_push && (n < D);
            pop_ok  = do_pop && (n > 0);
            fault   = (do_push && n == D) || (do_pop && n == 0);
            if (pop_ok) begin
                data_q.push_back(mdl_q[0]);
                void'(mdl_q.pop_front());
            end
            if (push_ok) begin
                mdl_q.push_back(d);
            end
            mdl_err = mdl_err | fault;
`ifdef SYNC_FIFO_DIAG_EN
            if (do_diag) begin
                mdl_err = 1'b0;
            end
`endif
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
    endtask

    // Monitor: flags every cycle, popped word whenever the DUT accepts a pop.
    initial begin
        logic [5:0] s;
        forever begin
            @(negedge clk);
            if (stat_q.size() > 0) begin
                s = stat_q.pop_front();
                check("flags{e,ae,hf,af,f,err}",
                      {26'd0, empty, almost_empty, half_full, almost_full, full, error},
                      {26'd0, s});
            end
            if (!rst && !pop_req_n && !empty) begin
                if (data_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL pop_unexpected actual=%0h expected=no_pop at %0t", data_out, $time);
                end else begin
                    check("pop_data", {16'd0, data_out}, {16'd0, data_q.pop_front()});
                end
            end
        end
    end

    initial begin
        rst        = 1'b1;
        push_req_n = 1'b1;
        pop_req_n  = 1'b1;
        diag_n     = 1'b1;
        data_in    = '0;
        mdl_err    = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state held while idle.
        repeat (2) idle();

        // Fill with 1..5, flags walk through every level.
        for (int i = 1; i <= D; i++) begin
            drive(1'b1, 1'b0, W'(i), 1'b0, 1'b0);
        end
        idle();

        // Drain: words come out in order, ending empty with no error.
        repeat (D) drive(1'b0, 1'b1, '0, 1'b0, 1'b0);
        repeat (2) idle();

        // Simultaneous push+pop at count 2 across pointer wrap.
        drive(1'b1, 1'b0, 16'h00a0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 16'h00a1, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 1'b1, W'($urandom), 1'b0, 1'b0);
        end
        repeat (2) drive(1'b0, 1'b1, '0, 1'b0, 1'b0);
        idle();

        // Overflow then underflow; sticky error, contents preserved.
        for (int i = 0; i < D; i++) begin
            drive(1'b1, 1'b0, W'($urandom), 1'b0, 1'b0);
        end
        drive(1'b1, 1'b0, 16'hdead, 1'b0, 1'b0);
        repeat (2) idle();
        repeat (D) drive(1'b0, 1'b1, '0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, '0, 1'b0, 1'b0);
        repeat (3) idle();

        // Reset mid-stream at count 3 with a push pending; then diagnostic clear.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, W'(16'h0300 + i), 1'b0, 1'b0);
        end
        drive(1'b1, 1'b1, 16'hbeef, 1'b1, 1'b0);
        repeat (2) idle();
        drive(1'b0, 1'b1, '0, 1'b0, 1'b0);
        idle();
        drive(1'b0, 1'b0, '0, 1'b0, 1'b1);
        repeat (2) idle();
        drive(1'b0, 1'b0, '0, 1'b1, 1'b0);

        // Randomized traffic with occasional reset and diagnostic clear.
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), W'($urandom),
                  ($urandom_range(0, 63) == 0), ($urandom_range(0, 31) == 0));
        end
        idle();
        for (int i = 0; i <= D; i++) begin
            if (mdl_q.size() > 0) begin
                drive(1'b0, 1'b1, '0, 1'b0, 1'b0);
            end
        end
        repeat (2) idle();

        check("sb_data_left", data_q.size(), 32'd0);
        check("sb_stat_left", stat_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
